// File: rtl/menu_controller.sv
`timescale 1ns/1ps
// menu_controller: four-key game menu front end.
//   Each raw key is synchronized and debounced by its own menu_debounce lane,
//   which emits a one-cycle press pulse on an accepted 0->1 level change. A
//   MENU/START/PLAY/OVER FSM moves an internal cursor, latches the selected
//   row and launches/ends games. All outputs are registered.
// Ports:
//   CLOCK_50    in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   key_up/key_down/key_sel/key_back  in  raw buttons, high = pressed
//   frame_end   in   one-cycle pulse after last visible pixel of a frame
//   game_over   in   one-cycle pulse from the running game
//   m           out  menu screen enable
//   cursor      out  cursor row, reloaded only on frame_end
//   game_sel    out  latched selected row
//   game_start  out  one-cycle launch pulse
//   game_active out  high while a game is running
// Build option: define MENU_WRAP_EN to make the cursor wrap at the ends of the
// list; otherwise it saturates at 0 and NUM_ITEMS-1.

module menu_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key,
  output logic press
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;

  // Level is accepted on the DEBOUNCE_CYCLES-th consecutive mismatching cycle;
  // press fires in the same edge that a 1 is accepted.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync  <= '0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], key};
      press <= 1'b0;
      if (sync[1] != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync[1];
          press <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module menu_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_ITEMS       = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_sel,
  input  logic       key_back,
  input  logic       frame_end,
  input  logic       game_over,
  output logic       m,
  output logic [1:0] cursor,
  output logic [1:0] game_sel,
  output logic       game_start,
  output logic       game_active
);
  localparam int NUM_KEYS = 4;
  localparam logic [1:0] LAST = 2'(NUM_ITEMS - 1);

  typedef enum logic [1:0] {MENU, START, PLAY, OVER} state_t;

  logic [NUM_KEYS-1:0] keys, press;
  assign keys = {key_back, key_sel, key_down, key_up};

  genvar g;
  generate
    for (g = 0; g < NUM_KEYS; g++) begin : g_key
      menu_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .key      (keys[g]),
        .press    (press[g])
      );
    end
  endgenerate

  logic p_up, p_dn, p_sel, p_back;
  assign {p_back, p_sel, p_dn, p_up} = press;

  state_t     state, state_nx;
  logic [1:0] cur_int, cur_nx, sel_nx, cur_inc, cur_dec;

`ifdef MENU_WRAP_EN
  assign cur_inc = (cur_int == LAST)  ? 2'd0 : cur_int + 2'd1;
  assign cur_dec = (cur_int == 2'd0)  ? LAST : cur_int - 2'd1;
`else
  assign cur_inc = (cur_int == LAST)  ? cur_int : cur_int + 2'd1;
  assign cur_dec = (cur_int == 2'd0)  ? 2'd0    : cur_int - 2'd1;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= MENU;
      cur_int     <= 2'd0;
      game_sel    <= 2'd0;
      cursor      <= 2'd0;
      m           <= 1'b1;
      game_start  <= 1'b0;
      game_active <= 1'b0;
    end else begin
      state       <= state_nx;
      cur_int     <= cur_nx;
      game_sel    <= sel_nx;
      // cur_int is the pre-move value here, so a coincident move shows next frame
      if (frame_end) cursor <= cur_int;
      m           <= (state_nx == MENU);
      game_start  <= (state_nx == START);
      game_active <= (state_nx == START) || (state_nx == PLAY);
    end
  end

  always_comb begin
    state_nx = state;
    cur_nx   = cur_int;
    sel_nx   = game_sel;
    case (state)
      MENU: begin
        // sel wins over any same-cycle move; up+down together cancel
        if (p_sel) begin
          sel_nx   = cur_int;
          state_nx = START;
        end else if (p_dn && !p_up) begin
          cur_nx = cur_inc;
        end else if (p_up && !p_dn) begin
          cur_nx = cur_dec;
        end
      end
      START: state_nx = PLAY;
      PLAY: begin
        if (game_over)   state_nx = OVER;
        else if (p_back) state_nx = MENU;
      end
      OVER: if (p_sel || p_back) state_nx = MENU;
      default: state_nx = MENU;
    endcase
  end
endmodule

// File: tb/tb_menu_controller.sv
`timescale 1ns/1ps
module tb_menu_controller;
  localparam int D = 4;
  localparam int N = 4;
`ifdef MENU_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  localparam int S_MENU = 0, S_START = 1, S_PLAY = 2, S_OVER = 3;

  logic CLOCK_50 = 1'b0, reset = 1'b0;
  logic key_up = 1'b0, key_down = 1'b0, key_sel = 1'b0, key_back = 1'b0;
  logic frame_end = 1'b0, game_over = 1'b0;
  logic m, game_start, game_active;
  logic [1:0] cursor, game_sel;

  always #10 CLOCK_50 = ~CLOCK_50;

  menu_controller #(.DEBOUNCE_CYCLES(D), .NUM_ITEMS(N)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .key_up(key_up), .key_down(key_down), .key_sel(key_sel), .key_back(key_back),
    .frame_end(frame_end), .game_over(game_over),
    .m(m), .cursor(cursor), .game_sel(game_sel),
    .game_start(game_start), .game_active(game_active)
  );

  typedef struct packed {
    logic       m;
    logic [1:0] cursor;
    logic [1:0] game_sel;
    logic       game_start;
    logic       game_active;
  } snap_t;

  snap_t exp_q[$];
  snap_t cur_exp, obs, prev, e;
  int    n_chk = 0, n_fail = 0;
  bit    mon_en = 1'b0;

  // reference model: menu state, internal cursor, shown cursor, selection
  int st = S_MENU, cur = 0, fcur = 0, gsel = 0;

  function automatic snap_t snap();
    snap_t s;
    s.m           = (st == S_MENU);
    s.cursor      = 2'(fcur);
    s.game_sel    = 2'(gsel);
    s.game_start  = (st == S_START);
    s.game_active = (st == S_START) || (st == S_PLAY);
    return s;
  endfunction

  task automatic push();
    snap_t s;
    s = snap();
    if (s != cur_exp) begin
      exp_q.push_back(s);
      cur_exp = s;
    end
  endtask

  // monitor: every visible output change consumes one expected snapshot
  always @(negedge CLOCK_50) begin
    obs = {m, cursor, game_sel, game_start, game_active};
    if (mon_en && obs !== prev) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change got=%b expected_none", obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          n_fail++;
          $display("FAIL output_event got=%b exp=%b (m,cur,sel,start,active)", obs, e);
        end
      end
    end
    prev = obs;
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s pending_events got=%0d exp=0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  // model of one debounced press set; mk = {back,sel,down,up}
  task automatic model_press(input logic [3:0] mk, input bit fe, input bit go);
    bit up, dn, sl, bk;
    {bk, sl, dn, up} = mk;
    if (fe) fcur = cur;
    case (st)
      S_MENU: begin
        if (sl) begin
          gsel = cur; st = S_START; push(); st = S_PLAY;
        end else if (dn && !up) begin
          cur = WRAP ? (cur + 1) % N : ((cur + 1 > N - 1) ? N - 1 : cur + 1);
        end else if (up && !dn) begin
          cur = WRAP ? (cur + N - 1) % N : ((cur == 0) ? 0 : cur - 1);
        end
      end
      S_PLAY: begin
        if (go)      st = S_OVER;
        else if (bk) st = S_MENU;
      end
      S_OVER: if (sl || bk) st = S_MENU;
      default: ;
    endcase
    push();
  endtask

  // hold >= D+7 cycles: frame_end/game_over land on the press-pulse cycle
  task automatic drive(input logic [3:0] mk, input bit fe, input bit go, input int hold);
    @(posedge CLOCK_50); #1 {key_back, key_sel, key_down, key_up} = mk;
    if (hold < D + 7) begin
      repeat (hold) @(posedge CLOCK_50);
      #1 {key_back, key_sel, key_down, key_up} = 4'b0;
    end else begin
      repeat (D + 2) @(posedge CLOCK_50);
      #1 frame_end = fe; game_over = go;
      @(posedge CLOCK_50);
      #1 frame_end = 1'b0; game_over = 1'b0;
      repeat (hold - D - 3) @(posedge CLOCK_50);
      #1 {key_back, key_sel, key_down, key_up} = 4'b0;
    end
    repeat (D + 8) @(posedge CLOCK_50);
  endtask

  task automatic act(input logic [3:0] mk, input bit fe, input bit go);
    model_press(mk, fe, go);
    drive(mk, fe, go, D + 8);
    chk_idle("action");
  endtask

  task automatic act_glitch(input logic [3:0] mk);
    drive(mk, 1'b0, 1'b0, $urandom_range(1, D - 1));
    chk_idle("glitch");
  endtask

  task automatic act_reset();
    st = S_MENU; cur = 0; fcur = 0; gsel = 0;
    push();
    @(posedge CLOCK_50); #1 reset = 1'b1;
    @(posedge CLOCK_50); #1 reset = 1'b0;
    repeat (4) @(posedge CLOCK_50);
    chk_idle("reset");
  endtask

  initial begin
    logic [3:0] mk;
    // reset with key_down held through release
    reset = 1'b1; key_down = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("rst_m", m, 1);
    chk("rst_cursor", cursor, 0);
    chk("rst_game_sel", game_sel, 0);
    chk("rst_game_start", game_start, 0);
    chk("rst_game_active", game_active, 0);
    cur_exp = snap();
    mon_en = 1'b1;
    @(posedge CLOCK_50); #1 reset = 1'b0;
    model_press(4'b0010, 1'b0, 1'b0);   // held key counts as one new press
    repeat (D + 10) @(posedge CLOCK_50);
    #1 key_down = 1'b0;
    repeat (D + 8) @(posedge CLOCK_50);
    chk_idle("held_through_reset");
    act(4'b0000, 1'b1, 1'b0);           // frame_end shows cursor 1

    // directed boundaries
    act_glitch(4'b0010);
    act(4'b0000, 1'b1, 1'b0);
    act(4'b0010, 1'b0, 1'b0);
    act(4'b0010, 1'b0, 1'b0);           // cursor 3
    act(4'b0000, 1'b1, 1'b0);
    act(4'b0010, 1'b0, 1'b0);           // down at last row
    act(4'b0000, 1'b1, 1'b0);
    act(4'b0001, 1'b1, 1'b0);           // frame_end coincident with move
    act(4'b0000, 1'b1, 1'b0);
    act(4'b0011, 1'b0, 1'b0);           // up+down cancel
    act(4'b0000, 1'b1, 1'b0);
    act(4'b0110, 1'b0, 1'b0);           // sel+down: sel wins
    act(4'b1000, 1'b0, 1'b1);           // back+game_over -> OVER
    act(4'b1000, 1'b0, 1'b0);           // back -> MENU
    act(4'b0100, 1'b0, 1'b0);
    act_reset();                        // reset mid-game
    act(4'b0001, 1'b0, 1'b0);           // up at row 0
    act(4'b0000, 1'b1, 1'b0);

    // randomized actions
    for (int i = 0; i < 90; i++) begin
      case ($urandom_range(0, 11))
        0, 1:  act(4'b0010, $urandom_range(0, 1), 1'b0);
        2, 3:  act(4'b0001, $urandom_range(0, 1), 1'b0);
        4:     act(4'b0100, 1'b0, 1'b0);
        5:     act(4'b1000, 1'b0, $urandom_range(0, 1));
        6:     act(4'b0000, 1'b0, 1'b1);
        7:     act(4'b0000, 1'b1, 1'b0);
        8:     act(4'($urandom_range(0, 15)), $urandom_range(0, 1), $urandom_range(0, 1));
        9:     begin mk = 4'($urandom_range(1, 15)); act_glitch(mk); end
        10:    act(4'b0011, 1'b0, 1'b0);
        default: if ($urandom_range(0, 2) == 0) act_reset(); else act(4'b0110, 1'b0, 1'b0);
      endcase
    end

    @(negedge CLOCK_50);
    chk("final_m", m, (st == S_MENU) ? 1 : 0);
    chk("final_cursor", cursor, fcur);
    chk("final_game_sel", game_sel, gsel);
    chk("final_game_active", game_active, (st == S_PLAY) ? 1 : 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
